instruction_encoder: RTL and testbench

Inverse of the decode-stage field splitter. Packs RV32I instruction fields (opcode, rd, func3, rs1, rs2, func7, immediate) plus a format selector into a 32-bit instruction word. Each word is tagged with a sequential word address and emitted through a valid/ready output register. Sits between the test/boot program generator and the instruction-memory write port.

---
 rtl/instruction_encoder.sv | 122 ++++++++++++
 tb/tb_instruction_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV32I field packer with a one-deep valid/ready output register and word addressing.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            format,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            func3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            func7,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instruction,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err_format,
    output logic                  err_imm
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  accept;
    logic                  illegal;
    logic [31:0]           word;

    assign out_valid = (state == S_FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        word    = 32'h0000_0013;
        illegal = 1'b0;
        unique case (1'b1)
            (format == F_R): word = {func7, rs2, rs1, func3, rd, opcode};
            (format == F_I): word = {imm[11:0], rs1, func3, rd, opcode};
            (format == F_S): word = {imm[11:5], rs2, rs1, func3,
                                     imm[4:0], opcode};
            (format == F_B): word = {imm[12], imm[10:5], rs2, rs1, func3,
                                     imm[4:1], imm[11], opcode};
            (format == F_U): word = {imm[31:12], rd, opcode};
            (format == F_J): word = {imm[20], imm[10:1], imm[11],
                                     imm[19:12], rd, opcode};
            default:         illegal = 1'b1;
        endcase
    end

    // Flush outranks accept; in_ready is already low during flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_EMPTY;
            out_instruction <= '0;
            out_addr        <= START_ADDR;
            next_addr       <= START_ADDR;
        end else if (flush) begin
            state     <= S_EMPTY;
            out_addr  <= START_ADDR;
            next_addr <= START_ADDR;
        end else if (accept) begin
            state           <= S_FULL;
            out_instruction <= word;
            out_addr        <= next_addr;
            next_addr       <= next_addr + ADDR_WIDTH'(1);
        end else if (out_ready) begin
            state <= S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_format <= 1'b0;
        end else if (accept && illegal) begin
            err_format <= 1'b1;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;

    always_comb begin
        imm_bad = 1'b0;
        unique case (1'b1)
            (format == F_I),
            (format == F_S): imm_bad = imm[31:11] != {21{imm[11]}};
            (format == F_B): imm_bad = (imm[31:12] != {20{imm[12]}})
                                       || imm[0];
            (format == F_J): imm_bad = (imm[31:20] != {12{imm[20]}})
                                       || imm[0];
            (format == F_U): imm_bad = imm[11:0] != 12'h000;
            default:         imm_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_imm <= 1'b0;
        end else if (accept && imm_bad) begin
            err_imm <= 1'b1;
        end
    end
`else
    assign err_imm = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: table of hand-encoded words, scoreboard
// queue, plus backpressure, flush and async-reset sequences (ADDR_WIDTH=2).
module tb_instruction_encoder;

    localparam int AW = 2;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        bad;
    } vec_t;

    typedef struct {
        logic [31:0]   w;
        logic [AW-1:0] a;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    format = '0;
    logic [6:0]    opcode = '0;
    logic [4:0]    rd = '0;
    logic [2:0]    func3 = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [6:0]    func7 = '0;
    logic [31:0]   imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instruction;
    logic [AW-1:0] out_addr;
    logic          err_format;
    logic          err_imm;

    int nvec = 0;
    int nerr = 0;

    vec_t tv[14];
    exp_t q[$];

    logic [31:0]   cur_exp = '0;
    logic [2:0]    cur_fmt = '0;
    logic          cur_bad = 1'b0;
    logic          mfull = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic          merrf = 1'b0;
    logic          merri = 1'b0;
    logic          acc_flag = 1'b0;

    instruction_encoder #(.ADDR_WIDTH(AW), .START_ADDR('0)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .format(format),
        .opcode(opcode),
        .rd(rd),
        .func3(func3),
        .rs1(rs1),
        .rs2(rs2),
        .func7(func7),
        .imm(imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_addr(out_addr),
        .err_format(err_format),
        .err_imm(err_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rdv, input logic [2:0] f3,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [6:0] f7, input logic [31:0] iv,
                                input logic [31:0] exp, input logic bad);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rdv; v.f3 = f3;
        v.rs1 = r1; v.rs2 = r2; v.f7 = f7; v.imm = iv;
        v.exp = exp; v.bad = bad;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        format = v.fmt; opcode = v.op; rd = v.rd; func3 = v.f3;
        rs1 = v.rs1; rs2 = v.rs2; func7 = v.f7; imm = v.imm;
        cur_exp = v.exp; cur_fmt = v.fmt; cur_bad = v.bad;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 20);
        chk("accept_timeout", {31'd0, acc_flag}, 32'd1);
        #1;
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_ready, xfer, acc;
        exp_t e;
        if (reset) begin
            q.delete();
            mfull = 1'b0; maddr = '0;
            merrf = 1'b0; merri = 1'b0;
            acc_flag = 1'b0;
        end else begin
            exp_ready = !flush && (!mfull || out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, mfull});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("err_format", {31'd0, err_format}, {31'd0, merrf});
            chk("err_imm", {31'd0, err_imm}, {31'd0, merri});
            if (mfull) begin
                if (q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    chk("out_instruction", out_instruction, q[0].w);
                    chk("out_addr", {{(32-AW){1'b0}}, out_addr},
                        {{(32-AW){1'b0}}, q[0].a});
                end
            end
            xfer = mfull && out_ready && !flush;
            acc = in_valid && exp_ready;
            acc_flag = acc;
            if (flush) begin
                q.delete();
                mfull = 1'b0;
                maddr = '0;
            end else begin
                if (xfer && q.size() != 0) void'(q.pop_front());
                if (acc) begin
                    e.w = cur_exp;
                    e.a = maddr;
                    q.push_back(e);
                    maddr = maddr + 1'b1;
                    mfull = 1'b1;
                    if (cur_fmt > 3'd5) merrf = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
                    if (cur_bad) merri = 1'b1;
`endif
                end else if (xfer) begin
                    mfull = 1'b0;
                end
            end
        end
    end

    initial begin
        tv[0]  = mk(3'd0, 7'h33, 5'd3,  3'd0, 5'd1, 5'd2,  7'h00, 32'h0,
                    32'h002081B3, 1'b0);
        tv[1]  = mk(3'd1, 7'h13, 5'd5,  3'd0, 5'd0, 5'd0,  7'h00, 32'hFFFFFFFF,
                    32'hFFF00293, 1'b0);
        tv[2]  = mk(3'd3, 7'h63, 5'd0,  3'd0, 5'd1, 5'd2,  7'h00, 32'h8,
                    32'h00208463, 1'b0);
        tv[3]  = mk(3'd5, 7'h6F, 5'd1,  3'd0, 5'd0, 5'd0,  7'h00, 32'h800,
                    32'h001000EF, 1'b0);
        tv[4]  = mk(3'd2, 7'h23, 5'd9,  3'd2, 5'd1, 5'd2,  7'h00, 32'd12,
                    32'h0020A623, 1'b0);
        tv[5]  = mk(3'd4, 7'h37, 5'd10, 3'd0, 5'd0, 5'd0,  7'h00, 32'h12345000,
                    32'h12345537, 1'b0);
        tv[6]  = mk(3'd7, 7'h33, 5'd3,  3'd1, 5'd1, 5'd2,  7'h20, 32'h123,
                    32'h00000013, 1'b0);
        tv[7]  = mk(3'd0, 7'h33, 5'd5,  3'd0, 5'd6, 5'd7,  7'h20, 32'hDEADBEEF,
                    32'h407302B3, 1'b0);
        tv[8]  = mk(3'd3, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'hFFFFFFFC,
                    32'hFE000EE3, 1'b0);
        tv[9]  = mk(3'd5, 7'h6F, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'hFFFFFFF8,
                    32'hFF9FF06F, 1'b0);
        tv[10] = mk(3'd6, 7'h13, 5'd1,  3'd0, 5'd1, 5'd1,  7'h00, 32'h7,
                    32'h00000013, 1'b0);
        tv[11] = mk(3'd1, 7'h13, 5'd7,  3'd7, 5'd8, 5'd31, 7'h7F, 32'hFF,
                    32'h0FF47393, 1'b0);
        tv[12] = mk(3'd1, 7'h13, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'd2047,
                    32'h7FF00013, 1'b0);
        tv[13] = mk(3'd3, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'd7,
                    32'h00000363, 1'b1);

        #2 reset = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
        chk("rst_err_format", {31'd0, err_format}, 32'd0);
        chk("rst_err_imm", {31'd0, err_imm}, 32'd0);
        #18 reset = 1'b0;
        tick();

        // Full-throughput stream; addresses wrap modulo 4.
        for (int i = 0; i < 14; i++) begin
            drive(tv[i]);
            wait_acc();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("err_format_sticky", {31'd0, err_format}, 32'd1);
`ifdef IMM_RANGE_CHECK_EN
        chk("err_imm_after_b7", {31'd0, err_imm}, 32'd1);
`else
        chk("err_imm_off", {31'd0, err_imm}, 32'd0);
`endif

        // Backpressure with a second word pending.
        out_ready = 1'b0;
        drive(tv[0]);
        wait_acc();
        drive(tv[1]);
        repeat (3) tick();
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_word", out_instruction, tv[0].exp);
        out_ready = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        repeat (3) tick();

        // Flush while FULL with a word offered.
        out_ready = 1'b0;
        drive(tv[2]);
        wait_acc();
        drive(tv[3]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_addr", {30'd0, out_addr}, 32'd0);
        wait_acc();
        in_valid = 1'b0;
        #1;
        chk("post_flush_addr", {30'd0, out_addr}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset while a word is held.
        out_ready = 1'b0;
        drive(tv[5]);
        wait_acc();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_instruction", out_instruction, 32'd0);
        chk("mid_rst_out_addr", {30'd0, out_addr}, 32'd0);
        chk("mid_rst_err_format", {31'd0, err_format}, 32'd0);
        chk("mid_rst_err_imm", {31'd0, err_imm}, 32'd0);
        #4 reset = 1'b0;
        out_ready = 1'b1;
        tick();
        drive(tv[0]);
        wait_acc();
        drive(tv[13]);
        wait_acc();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
